// File: rtl/march_seq_if.sv
// March sequencer handshake/bus interface.
// Control side: start, alg_sel, data_bg, en, abort.
// Memory side: mem_addr, mem_we, mem_re, mem_wdata, exp_data, op_valid,
// elem_idx, busy, done.
// The master drives control and observes the memory side; the slave is the
// sequencer.
interface march_seq_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4
);
  logic                  start;
  logic [1:0]            alg_sel;
  logic [DATA_WIDTH-1:0] data_bg;
  logic                  en;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  op_valid;
  logic [2:0]            elem_idx;
  logic                  busy;
  logic                  done;

  modport master (
    output start, alg_sel, data_bg, en, abort,
    input  mem_addr, mem_we, mem_re, mem_wdata, exp_data, op_valid,
           elem_idx, busy, done
  );

  modport slave (
    input  start, alg_sel, data_bg, en, abort,
    output mem_addr, mem_we, mem_re, mem_wdata, exp_data, op_valid,
           elem_idx, busy, done
  );
endinterface

// File: rtl/march_seq_gen.sv
// March-test sequencer for SRAM BIST (MATS+, March X, March C-).
// Ports: clk, rst_n (async, active low), bus (march_seq_if.slave).
// One memory operation is presented per cycle while running with en high;
// every output is registered.
//
// state  | meaning
// IDLE   | waiting for start, outputs quiet
// RUN    | walking the element table, one op per enabled cycle
// DONE   | final op on the bus; next edge pulses done and returns to IDLE
module march_seq_gen #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input logic        clk,
  input logic        rst_n,
  march_seq_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // last: final element of the algorithm; two: (rX,w~X) pair, else single op;
  // rd0: first op is a read; b0: pattern bit of the first op.
  typedef struct packed {
    logic last;
    logic two;
    logic rd0;
    logic b0;
  } elem_t;

  function automatic elem_t elem_desc(input logic [1:0] alg, input logic [2:0] idx);
    elem_t d;
    d = '0;
    if (alg == 2'd0) begin
      case (idx)
        3'd1:    d = 4'b0110;
        3'd2:    d = 4'b1111;
        default: d = 4'b0000;
      endcase
    end else if (alg == 2'd1) begin
      case (idx)
        3'd1:    d = 4'b0110;
        3'd2:    d = 4'b0111;
        3'd3:    d = 4'b1010;
        default: d = 4'b0000;
      endcase
    end else begin
      case (idx)
        3'd1, 3'd3: d = 4'b0110;
        3'd2, 3'd4: d = 4'b0111;
        3'd5:       d = 4'b1010;
        default:    d = 4'b0000;
      endcase
    end
    return d;
  endfunction

  function automatic logic elem_down(input logic [1:0] alg, input logic [2:0] idx);
    if (alg[1]) return (idx == 3'd3) || (idx == 3'd4);
    return idx == 3'd2;
  endfunction

  state_t                state_q, state_d;
  logic [1:0]            alg_q, alg_d;
  logic [DATA_WIDTH-1:0] bg_q, bg_d;
  logic [2:0]            elem_q, elem_d;
  logic                  opi_q, opi_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  we_q, we_d, re_q, re_d, ov_q, ov_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d, ed_q, ed_d;
  logic [2:0]            eidx_q, eidx_d;
  logic                  busy_q, busy_d, done_q, done_d;

  elem_t                 cur;
  logic                  cur_down, op_rd, op_bit, addr_end;
  logic [DATA_WIDTH-1:0] pat;

  always_comb begin
    state_d    = state_q;
    alg_d      = alg_q;
    bg_d       = bg_q;
    elem_d     = elem_q;
    opi_d      = opi_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    ov_d       = 1'b0;
    wd_d       = wd_q;
    ed_d       = ed_q;
    eidx_d     = eidx_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    cur      = elem_desc(alg_q, elem_q);
    cur_down = elem_down(alg_q, elem_q);
    // The second op of a pair is always a write of the inverted bit.
    op_rd    = cur.rd0 && !opi_q;
    op_bit   = opi_q ? ~cur.b0 : cur.b0;
    pat      = {DATA_WIDTH{op_bit}} ^ bg_q;
    addr_end = cur_down ? (addr_q == '0) : (addr_q == LAST_ADDR);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          alg_d   = bus.alg_sel;
          bg_d    = bus.data_bg;
          elem_d  = '0;
          opi_d   = 1'b0;
          addr_d  = '0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          busy_d = 1'b1;
          if (bus.en) begin
            ov_d       = 1'b1;
            mem_addr_d = addr_q;
            eidx_d     = elem_q;
            if (op_rd) begin
              re_d = 1'b1;
              ed_d = pat;
            end else begin
              we_d = 1'b1;
              wd_d = pat;
            end
            if (cur.two && !opi_q) begin
              opi_d = 1'b1;
            end else begin
              opi_d = 1'b0;
              if (!addr_end) begin
                addr_d = cur_down ? addr_q - 1'b1 : addr_q + 1'b1;
              end else if (cur.last) begin
                state_d = S_DONE;
              end else begin
                elem_d = elem_q + 3'd1;
                addr_d = elem_down(alg_q, elem_q + 3'd1) ? LAST_ADDR : '0;
              end
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      alg_q      <= '0;
      bg_q       <= '0;
      elem_q     <= '0;
      opi_q      <= 1'b0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      ov_q       <= 1'b0;
      wd_q       <= '0;
      ed_q       <= '0;
      eidx_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      alg_q      <= alg_d;
      bg_q       <= bg_d;
      elem_q     <= elem_d;
      opi_q      <= opi_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      we_q       <= we_d;
      re_q       <= re_d;
      ov_q       <= ov_d;
      wd_q       <= wd_d;
      ed_q       <= ed_d;
      eidx_q     <= eidx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_re    = re_q;
  assign bus.mem_wdata = wd_q;
  assign bus.exp_data  = ed_q;
  assign bus.op_valid  = ov_q;
  assign bus.elem_idx  = eidx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_march_seq_gen.sv
module tb_march_seq_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [1:0] alg_sel = 2'd0;
  logic [3:0] data_bg = 4'd0;
  logic       en = 1'b0;
  logic       abort = 1'b0;

  // DUT 0: full 8-bit space; DUT 1: DEPTH=4 inside a 3-bit address space.
  march_seq_if #(.ADDR_WIDTH(8), .DATA_WIDTH(4)) if_a ();
  march_seq_if #(.ADDR_WIDTH(3), .DATA_WIDTH(4)) if_b ();

  assign if_a.start = start;   assign if_b.start = start;
  assign if_a.alg_sel = alg_sel; assign if_b.alg_sel = alg_sel;
  assign if_a.data_bg = data_bg; assign if_b.data_bg = data_bg;
  assign if_a.en = en;         assign if_b.en = en;
  assign if_a.abort = abort;   assign if_b.abort = abort;

  march_seq_gen #(.ADDR_WIDTH(8), .DATA_WIDTH(4), .DEPTH(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  march_seq_gen #(.ADDR_WIDTH(3), .DATA_WIDTH(4), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));

  typedef struct {
    int       addr;
    bit       we;
    logic [3:0] data;
    int       elem;
  } op_t;

  op_t  expq[2][$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_op_cyc[2];
  int   done_cnt[2];
  logic [3:0] last_wd[2];
  logic [3:0] last_ed[2];
  int   o_addr[2], o_elem[2];
  logic o_we[2], o_re[2], o_ov[2], o_busy[2], o_done[2];
  logic [3:0] o_wd[2], o_ed[2];

  task automatic chk(input string tag, input int d, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s[dut%0d]: observed %0d expected %0d", tag, d, obs, expv);
    end
  endtask

  task automatic sample();
    o_addr[0] = int'(if_a.mem_addr); o_addr[1] = int'(if_b.mem_addr);
    o_elem[0] = int'(if_a.elem_idx); o_elem[1] = int'(if_b.elem_idx);
    o_we[0] = if_a.mem_we;    o_we[1] = if_b.mem_we;
    o_re[0] = if_a.mem_re;    o_re[1] = if_b.mem_re;
    o_ov[0] = if_a.op_valid;  o_ov[1] = if_b.op_valid;
    o_busy[0] = if_a.busy;    o_busy[1] = if_b.busy;
    o_done[0] = if_a.done;    o_done[1] = if_b.done;
    o_wd[0] = if_a.mem_wdata; o_wd[1] = if_b.mem_wdata;
    o_ed[0] = if_a.exp_data;  o_ed[1] = if_b.exp_data;
  endtask

  // One March element over the whole address range: ops is e.g. "r0w1".
  task automatic add_elem(input int d, input int depth, input logic [3:0] bg,
                          input int e, input bit down, input string ops);
    op_t o;
    int a;
    for (int i = 0; i < depth; i++) begin
      a = down ? depth - 1 - i : i;
      for (int k = 0; k < ops.len(); k += 2) begin
        o.addr = a;
        o.we   = (ops[k] == "w");
        o.data = (ops[k+1] == "1") ? ~bg : bg;
        o.elem = e;
        expq[d].push_back(o);
      end
    end
  endtask

  task automatic build(input int d, input int depth, input int alg, input logic [3:0] bg);
    expq[d].delete();
    add_elem(d, depth, bg, 0, 0, "w0");
    add_elem(d, depth, bg, 1, 0, "r0w1");
    if (alg == 0) begin
      add_elem(d, depth, bg, 2, 1, "r1w0");
    end else if (alg == 1) begin
      add_elem(d, depth, bg, 2, 1, "r1w0");
      add_elem(d, depth, bg, 3, 0, "r0");
    end else begin
      add_elem(d, depth, bg, 2, 0, "r1w0");
      add_elem(d, depth, bg, 3, 1, "r0w1");
      add_elem(d, depth, bg, 4, 1, "r1w0");
      add_elem(d, depth, bg, 5, 0, "r0");
    end
  endtask

  task automatic step();
    bit en_s;
    op_t e;
    en_s = en;
    @(posedge clk);
    #1;
    cyc++;
    sample();
    for (int d = 0; d < 2; d++) begin
      if (o_ov[d]) begin
        if (expq[d].size() == 0) begin
          chk("extra_op", d, 1, 0);
        end else begin
          e = expq[d].pop_front();
          chk("addr", d, o_addr[d], e.addr);
          chk("we", d, int'(o_we[d]), int'(e.we));
          chk("re", d, int'(o_re[d]), int'(!e.we));
          chk("elem_idx", d, o_elem[d], e.elem);
          chk("busy_op", d, int'(o_busy[d]), 1);
          if (e.we) begin
            chk("wdata", d, int'(o_wd[d]), int'(e.data));
            chk("exp_hold", d, int'(o_ed[d]), int'(last_ed[d]));
            last_wd[d] = e.data;
          end else begin
            chk("exp_data", d, int'(o_ed[d]), int'(e.data));
            chk("wdata_hold", d, int'(o_wd[d]), int'(last_wd[d]));
            last_ed[d] = e.data;
          end
          last_op_cyc[d] = cyc;
        end
      end else begin
        chk("strobe_noop", d, int'(o_we[d] | o_re[d]), 0);
      end
      if (!en_s) chk("pause_ov", d, int'(o_ov[d]), 0);
      if (o_done[d]) begin
        done_cnt[d]++;
        chk("done_early", d, expq[d].size(), 0);
        chk("done_busy", d, int'(o_busy[d]), 0);
        chk("done_after_last", d, cyc - last_op_cyc[d], 1);
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    sample();
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_addr"}, d, o_addr[d], 0);
      chk({tag, "_elem"}, d, o_elem[d], 0);
      chk({tag, "_we"}, d, int'(o_we[d]), 0);
      chk({tag, "_re"}, d, int'(o_re[d]), 0);
      chk({tag, "_ov"}, d, int'(o_ov[d]), 0);
      chk({tag, "_busy"}, d, int'(o_busy[d]), 0);
      chk({tag, "_done"}, d, int'(o_done[d]), 0);
      chk({tag, "_wdata"}, d, int'(o_wd[d]), 0);
      chk({tag, "_exp"}, d, int'(o_ed[d]), 0);
    end
  endtask

  task automatic run(input int alg, input logic [3:0] bg, input bit rnd);
    int nops[2];
    int first_cyc[2];
    int done_cyc[2];
    build(0, 256, alg, bg);
    build(1, 4, alg, bg);
    for (int d = 0; d < 2; d++) begin
      nops[d] = expq[d].size();
      first_cyc[d] = -1;
      done_cyc[d] = -1;
      done_cnt[d] = 0;
    end
    alg_sel = 2'(alg);
    data_bg = bg;
    start = 1'b1;
    en = 1'b1;
    step();
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("start_busy", d, int'(o_busy[d]), 1);
      chk("start_ov", d, int'(o_ov[d]), 0);
    end
    for (int i = 0; i < 8000 && !(done_cnt[0] > 0 && done_cnt[1] > 0); i++) begin
      en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      for (int d = 0; d < 2; d++) begin
        if (o_ov[d] && first_cyc[d] < 0) first_cyc[d] = cyc;
        if (o_done[d]) done_cyc[d] = cyc;
      end
    end
    for (int d = 0; d < 2; d++) begin
      chk("done_cnt", d, done_cnt[d], 1);
      chk("ops_left", d, expq[d].size(), 0);
      if (!rnd) chk("done_latency", d, done_cyc[d] - first_cyc[d], nops[d]);
    end
    en = 1'b1;
  endtask

  initial begin
    int total;
    int n_a;
    for (int d = 0; d < 2; d++) begin
      last_wd[d] = '0;
      last_ed[d] = '0;
      last_op_cyc[d] = 0;
      done_cnt[d] = 0;
    end
    #2;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;

    run(0, 4'b0000, 0);                 // MATS+ ordering
    run(1, 4'b1010, 0);                 // data background with March X
    run(2, 4'($urandom_range(0, 15)), 0); // March C- full run
    run(3, 4'($urandom_range(0, 15)), 1); // March C- alias with random pauses

    // Abort at op 37, with an ignored start (and different alg) mid-run.
    build(0, 256, 2, 4'b0110);
    build(1, 4, 2, 4'b0110);
    total = expq[0].size();
    alg_sel = 2'd2; data_bg = 4'b0110; start = 1'b1; en = 1'b1;
    step();
    start = 1'b0;
    n_a = 0;
    for (int i = 0; i < 200 && n_a < 37; i++) begin
      start = (n_a == 10);
      alg_sel = (n_a == 10) ? 2'd0 : 2'd2;
      step();
      n_a = total - expq[0].size();
    end
    start = 1'b0;
    chk("abort_reach", 0, n_a, 37);
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("abort_busy", d, int'(o_busy[d]), 0);
      chk("abort_ov", d, int'(o_ov[d]), 0);
    end
    done_cnt[0] = 0; done_cnt[1] = 0;
    for (int i = 0; i < 3; i++) step();
    for (int d = 0; d < 2; d++) begin
      chk("abort_no_done", d, done_cnt[d], 0);
      expq[d].delete();
    end
    run(0, 4'b0011, 0);                 // clean restart

    // Asynchronous reset mid-run.
    build(0, 256, 1, 4'b1100);
    build(1, 4, 1, 4'b1100);
    alg_sel = 2'd1; data_bg = 4'b1100; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 30; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      expq[d].delete();
      last_wd[d] = '0;
      last_ed[d] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      step();
      for (int d = 0; d < 2; d++) chk("post_rst_busy", d, int'(o_busy[d]), 0);
    end
    run(1, 4'b1001, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
